// File: rtl/register_file_param.sv
// Parametrised register file: one write port, two combinational read ports,
// optional hardwired zero register, optional write-to-read forwarding and a
// per-register pending scoreboard for tracking in-flight producers.
module register_file_param #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [WIDTH-1:0]  data_writeReg,
    input  logic [ADDR_W-1:0] read_addr_A,
    input  logic [ADDR_W-1:0] read_addr_B,
    output logic [WIDTH-1:0]  data_readRegA,
    output logic [WIDTH-1:0]  data_readRegB,
    input  logic              set_pending,
    input  logic [ADDR_W-1:0] set_addr,
    output logic              busy_A,
    output logic              busy_B
);

    logic [WIDTH-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0] r_pending;
    logic [DEPTH-1:0] w_pendingNext;
    logic             w_writeLegal;
    logic             w_setLegal;
    logic             w_zeroA;
    logic             w_zeroB;
    logic             w_fwdA;
    logic             w_fwdB;

    // Register 0 is a discard target when it is hardwired to zero.
    assign w_writeLegal = write_enable && !((ZERO_REG != 0) && (write_addr == '0));
    assign w_setLegal   = set_pending  && !((ZERO_REG != 0) && (set_addr == '0));

    // Forwarding is suppressed during reset so reads show stored contents.
    assign w_fwdA  = (BYPASS != 0) && !reset && write_enable && (write_addr == read_addr_A);
    assign w_fwdB  = (BYPASS != 0) && !reset && write_enable && (write_addr == read_addr_B);
    assign w_zeroA = (ZERO_REG != 0) && (read_addr_A == '0);
    assign w_zeroB = (ZERO_REG != 0) && (read_addr_B == '0);

    // Data storage: reset clears every word and takes priority over a write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_writeLegal) begin
            r_regs[write_addr] <= data_writeReg;
        end
    end

    // Scoreboard next state: a write retires its producer, a newer set wins.
    always_comb begin
        w_pendingNext = r_pending;
        if (write_enable) begin
            w_pendingNext[write_addr] = 1'b0;
        end
        if (w_setLegal) begin
            w_pendingNext[set_addr] = 1'b1;
        end
        if (reset) begin
            w_pendingNext = '0;
        end
    end

    // Scoreboard state register.
    always_ff @(posedge clk) begin
        r_pending <= w_pendingNext;
    end

    // Read port A: zero register, then forwarded write, then stored word.
    always_comb begin
        data_readRegA = r_regs[read_addr_A];
        busy_A        = r_pending[read_addr_A];
        if (w_zeroA) begin
            data_readRegA = '0;
            busy_A        = 1'b0;
        end else if (w_fwdA) begin
            data_readRegA = data_writeReg;
            busy_A        = 1'b0;
        end
    end

    // Read port B: same selection rules as port A.
    always_comb begin
        data_readRegB = r_regs[read_addr_B];
        busy_B        = r_pending[read_addr_B];
        if (w_zeroB) begin
            data_readRegB = '0;
            busy_B        = 1'b0;
        end else if (w_fwdB) begin
            data_readRegB = data_writeReg;
            busy_B        = 1'b0;
        end
    end

endmodule

// File: tb/tb_register_file_param.sv
// Testbench for register_file_param: three instances (default, no forwarding,
// 8-bit x 4-entry) share one stimulus stream and are checked against a
// behavioural model every cycle, plus literal expectations on the default pair.
module tb_register_file_param;

    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        sp;
    logic [4:0]  sa;

    logic [31:0] dA0, dB0, dA1, dB1;
    logic [7:0]  dA2, dB2;
    logic        bA0, bB0, bA1, bB1, bA2, bB2;

    int assertions = 0;
    int failures   = 0;
    bit checkEn    = 0;

    // Instance k: 0 = 32x32 bypass, 1 = 32x32 no bypass, 2 = 8x4 bypass.
    int          depthOf  [3] = '{32, 32, 4};
    logic [31:0] maskOf   [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00FF};
    bit          bypassOf [3] = '{1'b1, 1'b0, 1'b1};

    logic [31:0] mRegs [3][32];
    bit          mPend [3][32];

    logic [31:0] actA [3];
    logic [31:0] actB [3];
    logic        actBusyA [3];
    logic        actBusyB [3];

    register_file_param dut (
        .clk(clk), .reset(reset), .write_enable(we), .write_addr(wa),
        .data_writeReg(wd), .read_addr_A(ra), .read_addr_B(rb),
        .data_readRegA(dA0), .data_readRegB(dB0), .set_pending(sp),
        .set_addr(sa), .busy_A(bA0), .busy_B(bB0)
    );

    register_file_param #(.BYPASS(0)) dutNoBypass (
        .clk(clk), .reset(reset), .write_enable(we), .write_addr(wa),
        .data_writeReg(wd), .read_addr_A(ra), .read_addr_B(rb),
        .data_readRegA(dA1), .data_readRegB(dB1), .set_pending(sp),
        .set_addr(sa), .busy_A(bA1), .busy_B(bB1)
    );

    register_file_param #(.WIDTH(8), .DEPTH(4)) dutSmall (
        .clk(clk), .reset(reset), .write_enable(we), .write_addr(wa[1:0]),
        .data_writeReg(wd[7:0]), .read_addr_A(ra[1:0]), .read_addr_B(rb[1:0]),
        .data_readRegA(dA2), .data_readRegB(dB2), .set_pending(sp),
        .set_addr(sa[1:0]), .busy_A(bA2), .busy_B(bB2)
    );

    assign actA[0] = dA0;
    assign actA[1] = dA1;
    assign actA[2] = {24'd0, dA2};
    assign actB[0] = dB0;
    assign actB[1] = dB1;
    assign actB[2] = {24'd0, dB2};
    assign actBusyA[0] = bA0;
    assign actBusyA[1] = bA1;
    assign actBusyA[2] = bA2;
    assign actBusyB[0] = bB0;
    assign actBusyB[1] = bB1;
    assign actBusyB[2] = bB2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected read data for instance k at address addr from the model state.
    function automatic logic [31:0] expRead(int k, logic [4:0] addr);
        int a;
        int w;
        a = int'(addr) % depthOf[k];
        w = int'(wa) % depthOf[k];
        if (a == 0) return 32'd0;
        if (bypassOf[k] && !reset && we && (w == a)) return wd & maskOf[k];
        return mRegs[k][a];
    endfunction

    // Expected busy flag for instance k at address addr from the model state.
    function automatic bit expBusy(int k, logic [4:0] addr);
        int a;
        int w;
        a = int'(addr) % depthOf[k];
        w = int'(wa) % depthOf[k];
        if (a == 0) return 1'b0;
        if (bypassOf[k] && !reset && we && (w == a)) return 1'b0;
        return mPend[k][a];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model state update: reset clears all, a write clears pending, a set wins.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                for (int i = 0; i < 32; i++) begin
                    mRegs[k][i] <= 32'd0;
                    mPend[k][i] <= 1'b0;
                end
            end else begin
                if (we && ((int'(wa) % depthOf[k]) != 0))
                    mRegs[k][int'(wa) % depthOf[k]] <= wd & maskOf[k];
                if (we)
                    mPend[k][int'(wa) % depthOf[k]] <= 1'b0;
                if (sp && ((int'(sa) % depthOf[k]) != 0))
                    mPend[k][int'(sa) % depthOf[k]] <= 1'b1;
            end
        end
    end

    // Every-cycle comparison of all instances against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            for (int k = 0; k < 3; k++) begin
                checkOutput($sformatf("inst%0d readA", k), actA[k], expRead(k, ra));
                checkOutput($sformatf("inst%0d readB", k), actB[k], expRead(k, rb));
                checkOutput($sformatf("inst%0d busyA", k), {31'd0, actBusyA[k]}, {31'd0, expBusy(k, ra)});
                checkOutput($sformatf("inst%0d busyB", k), {31'd0, actBusyB[k]}, {31'd0, expBusy(k, rb)});
            end
        end
    end

    task automatic applyStimulus(input logic iRst, input logic iWe, input logic [4:0] iWa,
                                 input logic [31:0] iWd, input logic [4:0] iRa,
                                 input logic [4:0] iRb, input logic iSp, input logic [4:0] iSa);
        @(posedge clk);
        #1;
        reset = iRst;
        we    = iWe;
        wa    = iWa;
        wd    = iWd;
        ra    = iRa;
        rb    = iRb;
        sp    = iSp;
        sa    = iSa;
        #2;
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; wa = '0; wd = '0; ra = '0; rb = '0; sp = 1'b0; sa = '0;
        applyStimulus(1, 0, 0, 32'h0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 32'h0, 5, 5, 0, 0);
        checkEn = 1;
        checkOutput("post-reset r5", dA0, 32'h0);
        checkOutput("post-reset busy r5", {31'd0, bA0}, 32'h0);

        // Reset clear after a write to r5.
        applyStimulus(0, 1, 5, 32'hDEAD_BEEF, 5, 5, 0, 0);
        checkOutput("bypass r5", dA0, 32'hDEAD_BEEF);
        applyStimulus(1, 0, 0, 32'h0, 5, 5, 0, 0);
        checkOutput("r5 during reset", dA0, 32'hDEAD_BEEF);
        applyStimulus(0, 0, 0, 32'h0, 5, 5, 0, 0);
        checkOutput("r5 after reset", dA0, 32'h0);
        checkOutput("busy r5 after reset", {31'd0, bA0}, 32'h0);

        // Register 0 ignores writes and pending sets.
        applyStimulus(0, 1, 0, 32'hFFFF_FFFF, 0, 0, 1, 0);
        checkOutput("r0 write cycle", dA0, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 0, 0, 0, 0);
        checkOutput("r0 after write", dA0, 32'h0);
        checkOutput("busy r0", {31'd0, bA0}, 32'h0);

        // Same-cycle forwarding versus next-cycle visibility.
        applyStimulus(0, 1, 7, 32'h1234_5678, 7, 7, 0, 0);
        checkOutput("bypass A r7", dA0, 32'h1234_5678);
        checkOutput("bypass B r7", dB0, 32'h1234_5678);
        checkOutput("no-bypass r7 before edge", dA1, 32'h0);
        checkOutput("small bypass r3", {24'd0, dA2}, 32'h78);
        applyStimulus(0, 0, 0, 32'h0, 7, 7, 0, 0);
        checkOutput("no-bypass r7 after edge", dA1, 32'h1234_5678);

        // Scoreboard set on r3, then cleared by a write two edges later.
        applyStimulus(0, 0, 0, 32'h0, 3, 3, 1, 3);
        checkOutput("busy r3 before set edge", {31'd0, bA0}, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 3, 3, 0, 0);
        checkOutput("busy r3 after set", {31'd0, bA0}, 32'h1);
        checkOutput("no-bypass busy r3", {31'd0, bA1}, 32'h1);
        applyStimulus(0, 0, 0, 32'h0, 3, 3, 0, 0);
        checkOutput("busy r3 held", {31'd0, bA0}, 32'h1);
        applyStimulus(0, 1, 3, 32'h00C0_FFEE, 3, 3, 0, 0);
        checkOutput("busy r3 forwarded", {31'd0, bA0}, 32'h0);
        checkOutput("no-bypass busy r3 write cycle", {31'd0, bA1}, 32'h1);
        checkOutput("r3 forwarded", dA0, 32'h00C0_FFEE);
        applyStimulus(0, 0, 0, 32'h0, 3, 3, 0, 0);
        checkOutput("busy r3 after write", {31'd0, bA0}, 32'h0);
        checkOutput("no-bypass busy r3 after write", {31'd0, bA1}, 32'h0);
        checkOutput("no-bypass r3 after write", dA1, 32'h00C0_FFEE);

        // Simultaneous set and write on r9: data lands and pending stays set.
        applyStimulus(0, 1, 9, 32'hCAFE_F00D, 9, 9, 1, 9);
        applyStimulus(0, 0, 0, 32'h0, 9, 9, 0, 0);
        checkOutput("r9 data", dA0, 32'hCAFE_F00D);
        checkOutput("r9 pending", {31'd0, bA0}, 32'h1);

        // Reset beats a concurrent write and suppresses forwarding.
        applyStimulus(0, 1, 4, 32'h1111_2222, 4, 4, 0, 0);
        applyStimulus(1, 1, 4, 32'hA5A5_A5A5, 4, 9, 1, 6);
        checkOutput("r4 during reset", dA0, 32'h1111_2222);
        checkOutput("r9 busy during reset", {31'd0, bB0}, 32'h1);
        applyStimulus(0, 0, 0, 32'h0, 4, 9, 0, 0);
        checkOutput("r4 after reset", dA0, 32'h0);
        checkOutput("r9 busy after reset", {31'd0, bB0}, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 6, 2, 0, 0);
        checkOutput("r6 busy after reset", {31'd0, bA0}, 32'h0);

        // Mixed traffic on all instances, checked by the model only.
        applyStimulus(0, 1, 2, 32'h0000_00AB, 2, 6, 1, 6);
        applyStimulus(0, 1, 6, 32'h5555_AAAA, 6, 2, 1, 2);
        applyStimulus(0, 1, 1, 32'h0000_1234, 2, 6, 1, 1);
        applyStimulus(0, 0, 0, 32'h0, 1, 2, 0, 0);
        applyStimulus(0, 0, 0, 32'h0, 6, 5, 0, 0);

        @(posedge clk);
        #1;
        checkEn = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
